mem_access: RTL and testbench

- MEM-stage memory access unit. Sits directly downstream of the EX/MEM pipeline register and consumes its mem_* outputs. Produces the write-back triple for the MEM/WB register.
- Runs a request/acknowledge data-bus transaction for loads and stores. Performs byte-lane steering, load extension and alignment checks.
- Raises stallreq_mem until the access completes, so the pipeline controller holds stages 0-4.

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access_lane.sv | 73 +++++++
 rtl/mem_access.sv | 179 +++++++++++++++++
 tb/tb_mem_access.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage memory access unit:
// ALU/memory opcode encodings, FSM states and access sizes.
package mem_access_pkg;

  localparam int ALU_OP_W = 8;
  typedef logic [ALU_OP_W-1:0] aluop_t;

  // Opcode encodings shared with the EX stage.
  localparam aluop_t ALUOP_NOP = 8'h00;
  localparam aluop_t ALUOP_ADD = 8'h20;
  localparam aluop_t ALUOP_LB  = 8'hE0;
  localparam aluop_t ALUOP_LH  = 8'hE1;
  localparam aluop_t ALUOP_LW  = 8'hE3;
  localparam aluop_t ALUOP_LBU = 8'hE4;
  localparam aluop_t ALUOP_LHU = 8'hE5;
  localparam aluop_t ALUOP_SB  = 8'hE8;
  localparam aluop_t ALUOP_SH  = 8'hE9;
  localparam aluop_t ALUOP_SW  = 8'hEB;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/mem_access_lane.sv
// Combinational byte-lane logic: decodes the memory opcode, produces byte
// enables, store-data replication and load extraction/extension.
module mem_access_lane
  import mem_access_pkg::*;
(
  input  aluop_t      memop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic        is_mem_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  size_e      size;
  logic       sign_ext;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  // Opcode decode into size / direction / signedness.
  always_comb begin
    is_mem_o  = 1'b0;
    is_load_o = 1'b0;
    size      = SZ_WORD;
    sign_ext  = 1'b0;
    case (memop_i)
      ALUOP_LB:  begin is_mem_o = 1'b1; is_load_o = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      ALUOP_LBU: begin is_mem_o = 1'b1; is_load_o = 1'b1; size = SZ_BYTE; end
      ALUOP_LH:  begin is_mem_o = 1'b1; is_load_o = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      ALUOP_LHU: begin is_mem_o = 1'b1; is_load_o = 1'b1; size = SZ_HALF; end
      ALUOP_LW:  begin is_mem_o = 1'b1; is_load_o = 1'b1; size = SZ_WORD; end
      ALUOP_SB:  begin is_mem_o = 1'b1; size = SZ_BYTE; end
      ALUOP_SH:  begin is_mem_o = 1'b1; size = SZ_HALF; end
      ALUOP_SW:  begin is_mem_o = 1'b1; size = SZ_WORD; end
      default:   ;
    endcase
  end

  // Byte enables, alignment check, store replication and load extension.
  always_comb begin
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    st_data_o  = st_data_i;
    ld_data_o  = ld_data_i;
    case (addr_lo_i)
      2'd0:    byte_sel = ld_data_i[7:0];
      2'd1:    byte_sel = ld_data_i[15:8];
      2'd2:    byte_sel = ld_data_i[23:16];
      default: byte_sel = ld_data_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    case (size)
      SZ_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = is_mem_o & addr_lo_i[0];
        st_data_o  = {2{st_data_i[15:0]}};
        ld_data_o  = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: begin
        misalign_o = is_mem_o & (addr_lo_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage memory access unit: runs a req/ack bus cycle for aligned loads
// and stores, stalls the pipeline until completion and builds the
// write-back triple for MEM/WB.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stop,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  aluop_t      mem_memop,
  input  logic [31:0] mem_maddr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stallreq_mem,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  // A zero TIMEOUT still needs a 1-bit counter; it just never triggers.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              is_mem, is_load, misalign, aligned_op;
  logic [3:0]        lane_be;
  logic [31:0]       lane_st_data, lane_ld_data;
  logic              unused_stop;

  assign unused_stop = ^{stop[5], stop[3:0]};

  mem_access_lane u_lane (
    .memop_i    (mem_memop),
    .addr_lo_i  (mem_maddr[1:0]),
    .st_data_i  (mem_reg2),
    .ld_data_i  (rdata_q),
    .is_mem_o   (is_mem),
    .is_load_o  (is_load),
    .misalign_o (misalign),
    .be_o       (lane_be),
    .st_data_o  (lane_st_data),
    .ld_data_o  (lane_ld_data)
  );

  assign aligned_op = is_mem & ~misalign;

  // Bus signals come straight from the latched request so they stay stable in BUS.
  assign dbus_req   = (state_q == ST_BUS);
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

  // Next-state logic for the IDLE -> BUS -> DONE transaction FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    be_d    = be_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (aligned_op) begin
          addr_d  = {mem_maddr[31:2], 2'b00};
          be_d    = lane_be;
          we_d    = ~is_load;
          wdata_d = lane_st_data;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = ST_DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT - 1'b1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Holding in DONE while MEM is stalled prevents reissuing the same op.
        if (!stop[4]) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= ZERO_WORD;
      addr_q  <= ZERO_WORD;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Write-back, stall and exception outputs.
  always_comb begin
    wb_wd        = NOP_REG_ADDR;
    wb_wreg      = 1'b0;
    wb_wdata     = ZERO_WORD;
    stallreq_mem = 1'b0;
    exc_adel     = 1'b0;
    exc_ades     = 1'b0;
    exc_bus      = 1'b0;
    if (rst) begin
      // Everything held at its idle value during reset.
    end else if (!is_mem) begin
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
    end else if (misalign) begin
      // Address error: the write is killed, no bus cycle is started.
      wb_wd    = mem_wd;
      wb_wdata = mem_wdata;
      exc_adel = is_load;
      exc_ades = ~is_load;
    end else if (state_q != ST_DONE) begin
      stallreq_mem = 1'b1;
    end else begin
      wb_wd   = mem_wd;
      exc_bus = err_q;
      if (is_load) begin
        wb_wreg  = mem_wreg & ~err_q;
        wb_wdata = lane_ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard testbench for mem_access: the driver pushes expected write-back
// and bus requests; a monitor and a bus responder pop and compare them.
module tb_mem_access;
  import mem_access_pkg::*;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        adel;
    logic        ades;
    logic        bexc;
    logic        chk_data;
  } out_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stop;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_maddr, mem_reg2;
  aluop_t      mem_memop;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        stallreq_mem, exc_adel, exc_ades, exc_bus;

  int   errors = 0;
  int   checks = 0;
  out_t out_q[$];
  bus_t bus_q[$];
  out_t mon_e;
  bus_t rsp_e;
  logic op_active = 1'b0;
  int   ack_wait = -1;
  logic [31:0] ack_data = '0;
  int   bus_cyc = 0;
  int   episodes = 0;
  logic late_pulse = 1'b0;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stop(stop),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_memop(mem_memop), .mem_maddr(mem_maddr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .stallreq_mem(stallreq_mem),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t mk_out(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                  input logic adel, input logic ades, input logic bexc, input logic chkd);
    out_t o;
    o.wd = wd; o.wreg = wreg; o.wdata = wdata;
    o.adel = adel; o.ades = ades; o.bexc = bexc; o.chk_data = chkd;
    return o;
  endfunction

  function automatic bus_t mk_bus(input logic [31:0] addr, input logic [3:0] be,
                                  input logic we, input logic [31:0] wdata);
    bus_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    return b;
  endfunction

  // Output monitor: every non-stalled cycle of an active op is one result.
  always @(negedge clk) begin
    if (!rst && op_active && !stallreq_mem) begin
      if (out_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got wd=%0d wreg=%0b expected no result", wb_wd, wb_wreg);
      end else begin
        mon_e = out_q.pop_front();
        chk("wb_wreg", 32'(wb_wreg), 32'(mon_e.wreg));
        chk("exc_adel", 32'(exc_adel), 32'(mon_e.adel));
        chk("exc_ades", 32'(exc_ades), 32'(mon_e.ades));
        chk("exc_bus", 32'(exc_bus), 32'(mon_e.bexc));
        if (mon_e.chk_data) begin
          chk("wb_wd", 32'(wb_wd), 32'(mon_e.wd));
          chk("wb_wdata", wb_wdata, mon_e.wdata);
        end
        $display("txn out: wd=%0d wreg=%0b wdata=%h adel=%0b ades=%0b bus=%0b",
                 wb_wd, wb_wreg, wb_wdata, exc_adel, exc_ades, exc_bus);
      end
    end
  end

  // Bus responder: checks each request episode and acks after ack_wait cycles.
  always @(negedge clk) begin
    if (dbus_req) begin
      if (bus_cyc == 0) begin
        episodes++;
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got req addr=%h expected none", dbus_addr);
        end else begin
          rsp_e = bus_q.pop_front();
          chk("dbus_addr", dbus_addr, rsp_e.addr);
          chk("dbus_be", 32'(dbus_be), 32'(rsp_e.be));
          chk("dbus_we", 32'(dbus_we), 32'(rsp_e.we));
          if (rsp_e.we) chk("dbus_wdata", dbus_wdata, rsp_e.wdata);
          $display("txn bus: addr=%h be=%b we=%0b wdata=%h", dbus_addr, dbus_be, dbus_we, dbus_wdata);
        end
      end
      if (ack_wait >= 0 && bus_cyc == ack_wait) begin
        dbus_ack = 1'b1; dbus_rdata = ack_data;
      end else begin
        dbus_ack = 1'b0;
      end
      bus_cyc++;
    end else begin
      bus_cyc = 0;
      if (late_pulse) begin
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF; late_pulse = 1'b0;
      end else begin
        dbus_ack = 1'b0;
      end
    end
  end

  task automatic do_op(input aluop_t op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] alu, input logic [4:0] wd, input logic wreg,
                       input int aw, input logic [31:0] rd, input out_t exp,
                       input logic has_bus, input bus_t b, input int exp_stall);
    int   stalls;
    logic done;
    @(posedge clk); #1;
    mem_memop = op; mem_maddr = addr; mem_reg2 = reg2; mem_wdata = alu;
    mem_wd = wd; mem_wreg = wreg;
    ack_wait = aw; ack_data = rd;
    out_q.push_back(exp);
    if (has_bus) bus_q.push_back(b);
    op_active = 1'b1;
    stalls = 0; done = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (!stallreq_mem) done = 1'b1;
      else begin
        chk("stall_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("stall_wb_wd", 32'(wb_wd), 32'd0);
        stalls++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: got stall still high expected completion within 40 cycles");
    end
    chk("stall_cycles", stalls, exp_stall);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_memop = ALUOP_NOP; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    op_active = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  bus_t nob;
  int   ep0;
  logic seen;

  initial begin
    nob = mk_bus(32'h0, 4'h0, 1'b0, 32'h0);
    rst = 1'b1; stop = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    mem_memop = ALUOP_NOP; mem_wd = 5'h1F; mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF;
    mem_maddr = 32'h0; mem_reg2 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_wd", 32'(wb_wd), 32'd0);
    chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_dbus_req", 32'(dbus_req), 32'd0);
    chk("rst_dbus_we", 32'(dbus_we), 32'd0);
    chk("rst_dbus_be", 32'(dbus_be), 32'd0);
    chk("rst_dbus_addr", dbus_addr, 32'd0);
    chk("rst_dbus_wdata", dbus_wdata, 32'd0);
    chk("rst_stall", 32'(stallreq_mem), 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades, exc_bus}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // SW word store, immediate ack.
    do_op(ALUOP_SW, 32'h100, 32'hDEADBEEF, 32'h100, 5'd5, 1'b1, 0, 32'h0,
          mk_out(5'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1,
          mk_bus(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF), 2);
    // LB byte 3, three wait cycles: 0x80 sign-extended.
    do_op(ALUOP_LB, 32'h203, 32'h0, 32'h203, 5'd7, 1'b1, 3, 32'h80FF_1234,
          mk_out(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          mk_bus(32'h200, 4'b1000, 1'b0, 32'h0), 5);
    // LHU upper half, zero-extended.
    do_op(ALUOP_LHU, 32'h202, 32'h0, 32'h202, 5'd8, 1'b1, 0, 32'h8001_0000,
          mk_out(5'd8, 1'b1, 32'h0000_8001, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          mk_bus(32'h200, 4'b1100, 1'b0, 32'h0), 2);
    // SH upper half with replicated data.
    do_op(ALUOP_SH, 32'h202, 32'h0000_ABCD, 32'h202, 5'd0, 1'b0, 0, 32'h0,
          mk_out(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1,
          mk_bus(32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD), 2);
    // Misaligned LW and SH: exceptions, no bus, no stall.
    do_op(ALUOP_LW, 32'h102, 32'h0, 32'h102, 5'd9, 1'b1, 0, 32'h0,
          mk_out(5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, nob, 0);
    do_op(ALUOP_SH, 32'h101, 32'h1234, 32'h101, 5'd0, 1'b0, 0, 32'h0,
          mk_out(5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, nob, 0);
    // LW without ack: times out after 4 BUS cycles.
    do_op(ALUOP_LW, 32'h400, 32'h0, 32'h400, 5'd10, 1'b1, -1, 32'h0,
          mk_out(5'd10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1,
          mk_bus(32'h400, 4'b1111, 1'b0, 32'h0), 5);
    // ADD right after the timeout passes straight through.
    do_op(ALUOP_ADD, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 1'b1, 0, 32'h0,
          mk_out(5'd3, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, nob, 0);
    // LH lower half, sign-extended; also shows err cleared.
    do_op(ALUOP_LH, 32'h200, 32'h0, 32'h200, 5'd11, 1'b1, 1, 32'h0000_8001,
          mk_out(5'd11, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          mk_bus(32'h200, 4'b0011, 1'b0, 32'h0), 3);
    // SB lane 1 and LBU lane 1, back to back.
    do_op(ALUOP_SB, 32'h301, 32'h0000_00A5, 32'h301, 5'd0, 1'b0, 0, 32'h0,
          mk_out(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1,
          mk_bus(32'h300, 4'b0010, 1'b1, 32'hA5A5_A5A5), 2);
    do_op(ALUOP_LBU, 32'h301, 32'h0, 32'h301, 5'd12, 1'b1, 0, 32'h0000_C300,
          mk_out(5'd12, 1'b1, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          mk_bus(32'h300, 4'b0010, 1'b0, 32'h0), 2);
    idle(2);

    // Reset during BUS, then a late ack while idle.
    @(posedge clk); #1;
    mem_memop = ALUOP_LW; mem_maddr = 32'h600; mem_wd = 5'd4; mem_wreg = 1'b1;
    ack_wait = -1;
    bus_q.push_back(mk_bus(32'h600, 4'b1111, 1'b0, 32'h0));
    seen = 1'b0;
    for (int g = 0; g < 10 && !seen; g++) begin
      @(negedge clk);
      if (dbus_req) seen = 1'b1;
    end
    chk("rst_test_req_seen", 32'(seen), 32'd1);
    rst = 1'b1; mem_memop = ALUOP_NOP; mem_wdata = 32'hCAFE_0001; mem_wd = 5'd2; mem_wreg = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_drop", 32'(dbus_req), 32'd0);
    @(posedge clk); #1 rst = 1'b0; late_pulse = 1'b1;
    ep0 = episodes;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_req", 32'(dbus_req), 32'd0);
      chk("late_ack_stall", 32'(stallreq_mem), 32'd0);
      chk("late_ack_wdata", wb_wdata, 32'hCAFE_0001);
    end
    chk("late_ack_episodes", episodes - ep0, 0);

    // stop[4] held in DONE: result held, exactly one bus episode.
    idle(1);
    stop = 6'b010000;
    ep0 = episodes;
    do_op(ALUOP_LW, 32'h500, 32'h0, 32'h500, 5'd9, 1'b1, 0, 32'h1122_3344,
          mk_out(5'd9, 1'b1, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          mk_bus(32'h500, 4'b1111, 1'b0, 32'h0), 2);
    @(posedge clk); #1 op_active = 1'b0;
    @(negedge clk);
    chk("stop_hold_req", 32'(dbus_req), 32'd0);
    chk("stop_hold_wdata", wb_wdata, 32'h1122_3344);
    @(negedge clk);
    chk("stop_hold_wreg", 32'(wb_wreg), 32'd1);
    chk("stop_hold_stall", 32'(stallreq_mem), 32'd0);
    stop = 6'b0; mem_memop = ALUOP_NOP;
    repeat (3) @(posedge clk);
    chk("stop_episodes", episodes - ep0, 1);

    idle(2);
    chk("out_q_empty", out_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
